// File: rtl/stopwatch_ctrl_pkg.sv
// Shared encodings for the stopwatch controller and its decade digit cells.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

  function automatic logic is_active(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_decade_cell.sv
// One mod-10 BCD digit: counts on en, synchronous clear, terminal count at 9.
module decade_cell
  import stopwatch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             tc
);

  logic [BCD_W-1:0] q_q, q_d;

  // >= rather than == so any out-of-range value falls back to 0 on the next count
  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (en)
      q_d = (q_q >= DIGIT_MAX) ? '0 : q_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q  = q_q;
  assign tc = (q_q == DIGIT_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear stopwatch: command FSM, tick prescaler, decade cascade, lap latch.
//   state | meaning
//   IDLE  | stopped, count and prescaler zeroed
//   RUN   | counting, live digits displayed
//   PAUSE | stopped, count and prescaler held
//   LAP   | counting, display frozen on lap latch
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int PRESCALE   = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_stop,
  input  logic                        lap,
  input  logic                        clear,
  output logic                        running,
  output logic                        tick,
  output logic [BCD_W*NUM_DIGITS-1:0] digits_out,
  output logic                        overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_e                        state_q, state_d;
  logic [PW-1:0]                 presc_q, presc_d;
  logic [BCD_W*NUM_DIGITS-1:0]   lap_q, lap_d, live;
  logic                          ovf_q, ovf_d;
  logic                          running_q, lap_sel_q;
  logic [NUM_DIGITS-1:0]         tc, en;
  logic                          all_wrap;
  logic                          clr_cnt;

  // Priority clear > start_stop > lap falls out of the if/else order per state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_stop) state_d = ST_RUN;
      ST_RUN:   if (start_stop) state_d = ST_PAUSE;
                else if (lap)   state_d = ST_LAP;
      ST_LAP:   if (start_stop) state_d = ST_PAUSE;
                else if (lap)   state_d = ST_RUN;
      ST_PAUSE: if (clear)      state_d = ST_IDLE;
                else if (start_stop) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign clr_cnt = (state_q == ST_PAUSE) && (state_d == ST_IDLE);
  assign tick    = is_active(state_q) && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr_cnt || state_q == ST_IDLE)
      presc_d = '0;
    else if (is_active(state_q))
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    en       = '0;
    all_wrap = tick;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      en[i]    = all_wrap;
      all_wrap = all_wrap & tc[i];
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    decade_cell u_cell (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .en  (en[i]),
      .q   (live[BCD_W*i +: BCD_W]),
      .tc  (tc[i])
    );
  end

  // Latch sees the pre-edge digits, so a coinciding tick is not captured
  always_comb begin
    lap_d = lap_q;
    if (state_d == ST_LAP && state_q != ST_LAP)
      lap_d = live;
    ovf_d = ovf_q;
    if (clr_cnt)
      ovf_d = 1'b0;
    else if (all_wrap)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      lap_q     <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
      lap_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
      running_q <= is_active(state_d);
      lap_sel_q <= (state_d == ST_LAP);
    end
  end

  assign running    = running_q;
  assign overflow   = ovf_q;
  assign digits_out = lap_sel_q ? lap_q : live;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: per-cycle scoreboard against an integer model plus a table of checkpoints.
module tb_stopwatch_ctrl;

  localparam int P    = 10;
  localparam int ND   = 2;
  localparam int MAXC = 100;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_stop = 1'b0;
  logic          lap = 1'b0;
  logic          clear = 1'b0;
  logic          running;
  logic          tick;
  logic [4*ND-1:0] digits_out;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.PRESCALE(P), .NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .running    (running),
    .tick       (tick),
    .digits_out (digits_out),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [4*ND-1:0] digits;
    logic            run;
    logic            ovf;
    logic            tck;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic            ss, lp, cl, r;
    int              n;
    logic [4*ND-1:0] dig;
    logic            run, ovf;
  } vec_t;

  vec_t vecs[28];

  // model state: 0 idle, 1 run, 2 pause, 3 lap
  int m_st = 0, m_presc = 0, m_cnt = 0, m_lap = 0;
  logic m_ovf = 1'b0;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic ss, lp, cl, r, input int n,
                              input logic [4*ND-1:0] dig, input logic run, ovf);
    vec_t v;
    v.ss = ss; v.lp = lp; v.cl = cl; v.r = r; v.n = n;
    v.dig = dig; v.run = run; v.ovf = ovf;
    return v;
  endfunction

  task automatic model_step(input logic ss, lp, cl, r);
    int ns;
    bit tk;
    exp_t e;
    if (r) begin
      m_st = 0; m_presc = 0; m_cnt = 0; m_lap = 0; m_ovf = 1'b0;
    end else begin
      tk = (m_st == 1 || m_st == 3) && (m_presc == P - 1);
      ns = m_st;
      case (m_st)
        0: if (ss) ns = 1;
        1: if (ss) ns = 2; else if (lp) ns = 3;
        2: if (cl) ns = 0; else if (ss) ns = 1;
        3: if (ss) ns = 2; else if (lp) ns = 1;
        default: ns = 0;
      endcase
      if (m_st != 3 && ns == 3) m_lap = m_cnt;
      if (m_st == 1 || m_st == 3) m_presc = (m_presc + 1) % P;
      else if (m_st == 0) m_presc = 0;
      if (m_st == 2 && ns == 0) begin
        m_presc = 0; m_cnt = 0; m_ovf = 1'b0;
      end else if (tk) begin
        m_cnt++;
        if (m_cnt == MAXC) begin
          m_cnt = 0; m_ovf = 1'b1;
        end
      end
      m_st = ns;
    end
    e.digits = to_bcd((m_st == 3) ? m_lap : m_cnt);
    e.run    = (m_st == 1 || m_st == 3);
    e.ovf    = m_ovf;
    e.tck    = e.run && (m_presc == P - 1);
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic ss, lp, cl, r);
    exp_t e, got;
    @(negedge clk);
    start_stop = ss; lap = lp; clear = cl; rst = r;
    model_step(ss, lp, cl, r);
    @(posedge clk);
    #1;
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0; rst = 1'b0;
    cyc++;
    got = {digits_out, running, overflow, tick};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty cycle %0d", cyc);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL sb cycle %0d got dig=%h run=%b ovf=%b tick=%b exp dig=%h run=%b ovf=%b tick=%b",
                 cyc, got.digits, got.run, got.ovf, got.tck, e.digits, e.run, e.ovf, e.tck);
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(L, L, L, H,   1, 8'h00, L, L);
    vecs[1]  = mk(L, L, L, H,   1, 8'h00, L, L);
    vecs[2]  = mk(L, L, L, L,  50, 8'h00, L, L);
    vecs[3]  = mk(H, L, L, L,  11, 8'h01, H, L);
    vecs[4]  = mk(L, L, L, L,  80, 8'h09, H, L);
    vecs[5]  = mk(L, L, L, L,  10, 8'h10, H, L);
    vecs[6]  = mk(L, L, L, H,   2, 8'h00, L, L);
    vecs[7]  = mk(H, L, L, L,  15, 8'h01, H, L);
    vecs[8]  = mk(H, L, L, L,  40, 8'h01, L, L);
    vecs[9]  = mk(H, L, L, L,   5, 8'h01, H, L);
    vecs[10] = mk(L, L, L, L,   1, 8'h02, H, L);
    vecs[11] = mk(L, L, L, L,  10, 8'h03, H, L);
    vecs[12] = mk(L, H, L, L,  40, 8'h03, H, L);
    vecs[13] = mk(L, H, L, L,   1, 8'h07, H, L);
    vecs[14] = mk(L, L, L, L, 929, 8'h00, H, H);
    vecs[15] = mk(L, L, L, L,  10, 8'h01, H, H);
    vecs[16] = mk(H, L, L, L,   1, 8'h01, L, H);
    vecs[17] = mk(L, L, H, L,   1, 8'h00, L, L);
    vecs[18] = mk(H, L, L, L,  25, 8'h02, H, L);
    vecs[19] = mk(H, L, L, L,   1, 8'h02, L, L);
    vecs[20] = mk(H, L, H, L,   1, 8'h00, L, L);
    vecs[21] = mk(H, L, L, L,   3, 8'h00, H, L);
    vecs[22] = mk(L, H, L, H,   1, 8'h00, L, L);
    vecs[23] = mk(L, H, L, L,   5, 8'h00, L, L);
    vecs[24] = mk(L, L, H, L,   1, 8'h00, L, L);
    vecs[25] = mk(H, L, L, L,  30, 8'h02, H, L);
    vecs[26] = mk(L, H, L, L,   1, 8'h02, H, L);
    vecs[27] = mk(H, L, L, L,   1, 8'h03, L, L);

    for (int v = 0; v < 28; v++) begin
      cycle(vecs[v].ss, vecs[v].lp, vecs[v].cl, vecs[v].r);
      for (int j = 1; j < vecs[v].n; j++)
        cycle(L, L, L, L);
      checks++;
      if (digits_out !== vecs[v].dig || running !== vecs[v].run || overflow !== vecs[v].ovf) begin
        errors++;
        $display("FAIL row%0d got dig=%h run=%b ovf=%b exp dig=%h run=%b ovf=%b",
                 v, digits_out, running, overflow, vecs[v].dig, vecs[v].run, vecs[v].ovf);
      end
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
